mem_arbiter: RTL

N-channel memory arbiter sitting between requester modules (stimulus fetch, response check, future channels) and the single external memory bus. Grants one requester per bus transaction, forwards its command, and routes pipelined read data back to the issuing channel via an in-order tag queue. A parametrised successor to the fixed two-port memory interface: any channel count, any mix of reads and writes per channel, bounded outstanding reads.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/arb_tag_fifo.sv | 55 +++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
package mem_arb_pkg;

   // Widest channel count the one-hot decoder handles.
   localparam int MAX_CH = 64;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Channel ID width; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Index of the set bit of a one-hot vector (0 when no bit is set).
   function automatic int onehot_to_index(input logic [MAX_CH-1:0] onehot);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (onehot[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag queue: remembers which channel issued each outstanding read.
// Pop when empty is ignored; push when full only lands if a pop frees the slot
// in the same cycle.
module arb_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam int CNT_WIDTH = PTR_WIDTH + 1;

   logic [WIDTH-1:0]     slots [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_WIDTH'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = slots[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   // Tag storage; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (do_push) slots[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory arbiter: grants one requester per bus transaction,
// forwards its command and routes read data back in issue order.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration starting
// after the last accepted channel; without it the lowest eligible index wins.
// Handshake: a channel holds read or write with stable address/data until its
// ch_waitrequest is low; the command is accepted in that cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int MAX_PENDING = 8
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [N_CH*ADDR_WIDTH-1:0]   ch_address,
   input  logic [N_CH*BE_WIDTH-1:0]     ch_byteenable,
   input  logic [N_CH-1:0]              ch_read,
   input  logic [N_CH-1:0]              ch_write,
   input  logic [N_CH*DATA_WIDTH-1:0]   ch_writedata,
   output logic [N_CH-1:0]              ch_waitrequest,
   output logic [DATA_WIDTH-1:0]        ch_readdata,
   output logic [N_CH-1:0]              ch_readdataready,
   output logic [ADDR_WIDTH-1:0]        mem_address,
   output logic [BE_WIDTH-1:0]          mem_byteenable,
   output logic [DATA_WIDTH-1:0]        mem_writedata,
   output logic                         mem_read,
   output logic                         mem_write,
   input  logic [DATA_WIDTH-1:0]        mem_readdata,
   input  logic                         mem_readdataready,
   input  logic                         mem_waitrequest,
   output logic [$clog2(MAX_PENDING):0] pending_count,
   output logic                         err_orphan,
   output arb_state_t                   state
);
   localparam int CH_WIDTH = ch_width(N_CH);

   arb_state_t            state_r, state_d;
   logic [CH_WIDTH-1:0]   grant, grant_d, sel, tag_head;
   logic [N_CH-1:0]       eligible, rot;
   logic [MAX_CH-1:0]     oh_wide;
   int                    pick;
   logic                  tag_full, tag_empty, tag_push;
   logic                  g_read, g_write;

   assign state    = state_r;
   assign eligible = (ch_read & {N_CH{~tag_full}}) | ch_write;
   assign g_read   = ch_read[grant];
   assign g_write  = ch_write[grant];

`ifdef ARB_ROUND_ROBIN_EN
   logic [CH_WIDTH-1:0] rr_ptr;
   logic                accept;

   assign accept = (state_r == BUSY) && (g_read || g_write) && !mem_waitrequest;

   // Round-robin pointer remembers the last accepted channel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    rr_ptr <= CH_WIDTH'(N_CH - 1);
      else if (accept) rr_ptr <= grant;
   end
`endif

   // Winner selection: rotate so the search origin sits at bit 0, take the
   // lowest set bit, then undo the rotation.
   always_comb begin
      rot     = eligible;
      oh_wide = '0;
`ifdef ARB_ROUND_ROBIN_EN
      rot = N_CH'({eligible, eligible} >> ({1'b0, rr_ptr} + (CH_WIDTH+1)'(1)));
`endif
      oh_wide[N_CH-1:0] = rot & (~rot + N_CH'(1));
      pick = onehot_to_index(oh_wide);
`ifdef ARB_ROUND_ROBIN_EN
      pick = pick + int'(rr_ptr) + 1;
      if (pick >= N_CH) pick = pick - N_CH;
`endif
      sel = CH_WIDTH'(pick);
   end

   // FSM state and grant registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         grant   <= '0;
      end else begin
         state_r <= state_d;
         grant   <= grant_d;
      end
   end

   // Next state plus the muxed memory command; mem_* stay zero outside BUSY.
   always_comb begin
      state_d        = state_r;
      grant_d        = grant;
      tag_push       = 1'b0;
      ch_waitrequest = '1;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      case (state_r)
         IDLE: begin
            if (|eligible) begin
               grant_d = sel;
               state_d = BUSY;
            end
         end
         BUSY: begin
            mem_address           = ch_address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_byteenable        = ch_byteenable[int'(grant)*BE_WIDTH +: BE_WIDTH];
            mem_writedata         = ch_writedata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            mem_read              = g_read;
            mem_write             = g_write & ~g_read;
            ch_waitrequest[grant] = mem_waitrequest;
            if (!(g_read || g_write)) begin
               // Requester abandoned its command: nothing goes to memory.
               state_d = IDLE;
            end else if (!mem_waitrequest) begin
               tag_push = g_read;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Return routing: the queue head names the channel owning this beat.
   always_comb begin
      ch_readdataready = '0;
      if (mem_readdataready && !tag_empty) ch_readdataready[tag_head] = 1'b1;
   end

   assign ch_readdata = mem_readdata;

   // Sticky flag for read data that no outstanding read can own.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                             err_orphan <= 1'b0;
      else if (mem_readdataready && tag_empty)  err_orphan <= 1'b1;
   end

   arb_tag_fifo #(
      .WIDTH (CH_WIDTH),
      .DEPTH (MAX_PENDING)
   ) u_tags (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (tag_push),
      .push_data (grant),
      .pop       (mem_readdataready),
      .pop_data  (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (pending_count)
   );

endmodule
